fetch_unit: RTL and testbench

Instruction fetch stage of the 5-stage pipeline: holds the program counter, issues one instruction-memory request at a time over a req/ack handshake, and presents `Instruction` and `PCAddResult` to the IF/ID register each cycle. It honours `IFIDWrite` stalls from the hazard unit and redirects from the MEM stage, where branches and jumps are resolved. When no instruction is available, it supplies a NOP bubble.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_pc_register.sv | 17 +
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and fixed instruction words.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;

    modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemData);
    modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemData);
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter register; load data is forced word-aligned.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [31:0] D,
    output logic [31:0] Q
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    Q <= RESET_PC;
        else if (Load) Q <= D & ~32'd3;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID stall hold,
// and MEM-stage redirects that never abandon an in-flight handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               IFIDWrite,
    input  logic               Redirect,
    input  logic [31:0]        RedirectTarget,
    fetch_unit_if.master       imem,
    output logic [31:0]        Instruction,
    output logic [31:0]        PCAddResult,
    output logic               FetchValid,
    output logic [31:0]        PC
);

    fetch_state_e state;
    logic [31:0]  HoldInstr;
    logic [31:0]  DrainAddr;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_d;
    logic         pc_load;
    logic         fetch_ack;

    assign pc_plus4  = PC + PC_INC;
    assign fetch_ack = (state == FETCH) && imem.ImemAck;

    // Redirect wins in every state; otherwise advance only when IF/ID takes the word.
    always_comb begin
        pc_load = 1'b0;
        pc_d    = pc_plus4;
        if (Redirect) begin
            pc_load = 1'b1;
            pc_d    = RedirectTarget;
        end else if (IFIDWrite && (fetch_ack || state == HOLD)) begin
            pc_load = 1'b1;
        end
    end

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (pc_load),
        .D     (pc_d),
        .Q     (PC)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            HoldInstr <= NOP;
            DrainAddr <= '0;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (Redirect) begin
                        // Un-acked request must still complete at its original address.
                        if (!imem.ImemAck) begin
                            DrainAddr <= PC;
                            state     <= DRAIN;
                        end
                    end else if (imem.ImemAck && !IFIDWrite) begin
                        HoldInstr <= imem.ImemData;
                        state     <= HOLD;
                    end
                end
                HOLD:  if (Redirect || IFIDWrite) state <= FETCH;
                DRAIN: if (imem.ImemAck) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        imem.ImemReq  = (state == FETCH) || (state == DRAIN);
        imem.ImemAddr = (state == DRAIN) ? DrainAddr : PC;
        FetchValid    = fetch_ack || (state == HOLD);
        Instruction   = (state == HOLD) ? HoldInstr :
                        fetch_ack       ? imem.ImemData : NOP;
        PCAddResult   = FetchValid ? pc_plus4 : 32'h0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a programmable-latency imem model.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IFIDWrite = 1'b1;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic [31:0] Instruction, PCAddResult, PC;
    logic        FetchValid;

    int          lat = 0;
    logic [31:0] dxor = '0;
    int          cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IFIDWrite      (IFIDWrite),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .imem           (bus),
        .Instruction    (Instruction),
        .PCAddResult    (PCAddResult),
        .FetchValid     (FetchValid),
        .PC             (PC)
    );

    always #5 Clk = ~Clk;

    // Memory acks once a request has been held for `lat` cycles; data = addr ^ dxor.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                              cnt <= 0;
        else if (bus.ImemReq && !bus.ImemAck)    cnt <= cnt + 1;
        else                                     cnt <= 0;
    end

    always_comb begin
        bus.ImemAck  = bus.ImemReq && (cnt >= lat);
        bus.ImemData = bus.ImemAddr ^ dxor;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        IFIDWrite = 1'b1;
        Redirect = 1'b0;
        RedirectTarget = '0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
    endtask

    initial begin
        // Reset held, zero-wait memory returning the address
        lat = 0; dxor = '0;
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_req",   32'(bus.ImemReq), 32'd0);
        chk("rst_addr",  bus.ImemAddr,     32'h0);
        chk("rst_fv",    32'(FetchValid),  32'd0);
        chk("rst_instr", Instruction,      32'h0);
        chk("rst_pca",   PCAddResult,      32'h0);
        Reset = 1'b1;
        #1;
        chk("c1_fv",  32'(FetchValid), 32'd0);
        chk("c1_req", 32'(bus.ImemReq), 32'd0);
        chk("c1_pc",  PC,               32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("seq_fv",    32'(FetchValid), 32'd1);
            chk("seq_instr", Instruction,     32'(i * 4));
            chk("seq_pca",   PCAddResult,     32'(i * 4 + 4));
        end

        // Two wait states, then IF/ID stall for 3 cycles starting at the ack
        lat = 2; dxor = 32'hCAFE_0000;
        do_reset();
        cyc(); #1;
        chk("ws_noack_fv", 32'(FetchValid), 32'd0);
        chk("ws_nop",      Instruction,     32'h0);
        cyc(); #1;
        chk("ws_noack2_fv", 32'(FetchValid), 32'd0);
        cyc(); IFIDWrite = 1'b0; #1;
        chk("ws_ack_fv",    32'(FetchValid), 32'd1);
        chk("ws_ack_instr", Instruction,     32'hCAFE_0000);
        chk("ws_ack_pca",   PCAddResult,     32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc(); IFIDWrite = (i == 2); #1;
            chk("hold_state", 32'(dut.state),  32'd2);
            chk("hold_instr", Instruction,     32'hCAFE_0000);
            chk("hold_pca",   PCAddResult,     32'h4);
            chk("hold_req",   32'(bus.ImemReq), 32'd0);
            chk("hold_pc",    PC,               32'h0);
        end
        cyc(); #1;
        chk("resume_addr", bus.ImemAddr,     32'h4);
        chk("resume_req",  32'(bus.ImemReq), 32'd1);
        chk("resume_fv",   32'(FetchValid),  32'd0);

        // Redirect one cycle before the ack of a pending request
        lat = 2; dxor = '0;
        do_reset();
        cyc(); #1;
        cyc(); Redirect = 1'b1; RedirectTarget = 32'h40; #1;
        chk("rd_fv", 32'(FetchValid), 32'd0);
        cyc(); Redirect = 1'b0; #1;
        chk("drain_state", 32'(dut.state),  32'd3);
        chk("drain_addr",  bus.ImemAddr,     32'h0);
        chk("drain_req",   32'(bus.ImemReq), 32'd1);
        chk("drain_ack",   32'(bus.ImemAck), 32'd1);
        chk("drain_fv",    32'(FetchValid),  32'd0);
        chk("drain_pc",    PC,               32'h40);
        cyc(); #1;
        chk("post_drain_addr", bus.ImemAddr, 32'h40);
        chk("post_drain_fv",   32'(FetchValid), 32'd0);
        cyc(); cyc(); #1;
        chk("tgt_instr", Instruction, 32'h40);
        chk("tgt_pca",   PCAddResult, 32'h44);

        // Redirect and stall together while holding
        lat = 0; dxor = 32'hCAFE_0000;
        do_reset();
        cyc(); IFIDWrite = 1'b0; #1;
        chk("rs_ack_instr", Instruction, 32'hCAFE_0000);
        cyc(); Redirect = 1'b1; RedirectTarget = 32'h100; #1;
        chk("rs_hold_state", 32'(dut.state), 32'd2);
        cyc(); Redirect = 1'b0; IFIDWrite = 1'b1; #1;
        chk("rs_state", 32'(dut.state), 32'd1);
        chk("rs_pc",    PC,             32'h100);
        chk("rs_instr", Instruction,    32'hCAFE_0100);
        chk("rs_pca",   PCAddResult,    32'h104);

        // Redirect to an unaligned top-of-memory target; PC+4 wraps
        lat = 0; dxor = '0;
        do_reset();
        cyc(); Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFF; #1;
        chk("wr_first", Instruction, 32'h0);
        cyc(); Redirect = 1'b0; #1;
        chk("wr_addr",  bus.ImemAddr, 32'hFFFF_FFFC);
        chk("wr_instr", Instruction,  32'hFFFF_FFFC);
        chk("wr_pca",   PCAddResult,  32'h0);
        cyc(); #1;
        chk("wr_next_addr", bus.ImemAddr, 32'h0);
        chk("wr_next_pca",  PCAddResult,  32'h4);

        // Asynchronous reset while draining
        lat = 2; dxor = '0;
        do_reset();
        cyc(); Redirect = 1'b1; RedirectTarget = 32'h80; #1;
        cyc(); Redirect = 1'b0; #1;
        chk("ar_state_pre", 32'(dut.state),  32'd3);
        chk("ar_req_pre",   32'(bus.ImemReq), 32'd1);
        Reset = 1'b0;
        #1;
        chk("ar_req",   32'(bus.ImemReq), 32'd0);
        chk("ar_addr",  bus.ImemAddr,     32'h0);
        chk("ar_pc",    PC,               32'h0);
        chk("ar_fv",    32'(FetchValid),  32'd0);
        chk("ar_instr", Instruction,      32'h0);
        chk("ar_pca",   PCAddResult,      32'h0);
        chk("ar_state", 32'(dut.state),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
